handshake_fifo_arbiter: RTL and testbench
=========================================

HANDSHAKE_FIFO_ARBITER -- requirements
Module: handshake_fifo_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data bits per transfer.
REQ-002 Parameter PORTS, default 4, number of requesters (legal range 2..16).
REQ-003 Parameter BURST_MAX, default 4, maximum consecutive transfers granted to one port (legal range 1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clk_en  input  1  clock enable; state holds when low.
REQ-006 sync_rst  input  1  reset, synchronous, active-high.
REQ-007 InputREQ  input  PORTS  per-port request (data valid).
REQ-008 InputACK  output  PORTS  per-port acknowledge (transfer accepted).
REQ-009 InputData  input  PORTS*WIDTH  port i data in bits [i*WIDTH +: WIDTH].
REQ-010 OutputREQ  output  1  registered request toward the shared FIFO write port.
REQ-011 OutputACK  input  1  FIFO write acknowledge.
REQ-012 OutputData  output  WIDTH  registered data toward FIFO.

Function
REQ-013 An input transfer on port i SHALL occur in a cycle iff clk_en & InputREQ[i] & InputACK[i]; an output transfer iff clk_en & OutputREQ & OutputACK.
REQ-014 CanLoad SHALL be ~OutputREQ | OutputACK; InputACK[i] SHALL be clk_en & CanLoad & InputREQ[i] & (i == Grant); at most one InputACK bit high per cycle.
REQ-015 The arbiter SHALL have states IDLE and LOCKED, plus registers Pointer (clog2(PORTS) bits), LockPort and Count (8 bits).
REQ-016 IDLE: Grant = first port with InputREQ high searching cyclically from Pointer upward; no requests -> no grant, state holds.
REQ-017 IDLE transfer on port g: BURST_MAX==1 -> Pointer <= (g+1) mod PORTS, stay IDLE; else -> LOCKED, LockPort <= g, Count <= 1.
REQ-018 LOCKED: Grant = LockPort only; other ports SHALL NOT be acknowledged.
REQ-019 LOCKED transfer: Count <= Count+1; if Count+1 == BURST_MAX -> IDLE, Pointer <= (LockPort+1) mod PORTS.
REQ-020 LOCKED with clk_en high and InputREQ[LockPort] low -> IDLE, Pointer <= (LockPort+1) mod PORTS, no transfer that cycle.
REQ-021 LOCKED with InputREQ[LockPort] high but CanLoad low (FIFO backpressure): state, Count, Pointer hold; lock is not released.
REQ-022 Output stage: on input transfer, OutputData <= granted port data and OutputREQ <= 1 (same edge, overriding a simultaneous output transfer); else on output transfer OutputREQ <= 0; else hold.
REQ-023 Latency: one cycle input-to-output; sustained throughput one word per cycle when OutputACK stays high.
REQ-024 OutputData SHALL remain stable while OutputREQ high and OutputACK low.
REQ-025 clk_en low: no register changes; InputACK all zero.

Reset
REQ-026 sync_rst high at a rising edge SHALL set OutputREQ=0, OutputData=0, state=IDLE, Pointer=0, LockPort=0, Count=0; sync_rst SHALL take priority over clk_en.
REQ-027 While sync_rst is high InputACK SHALL be all zero; a word held in the output stage is discarded, a lock in progress is dropped.

Configuration
REQ-028 Macro HANDSHAKE_FIFO_ARBITER_TAG_EN defined: add output OutputTag [clog2(PORTS)-1:0], registered with OutputData, holding the source port index, reset 0.
REQ-029 Macro not defined: no OutputTag port, no tag register; all other behaviour identical.

Verification
REQ-030 Reset, PORTS=4, BURST_MAX=1, all four REQ high, OutputACK high -> OutputData sources 0,1,2,3,0 on consecutive cycles, OutputREQ high from cycle 2.
REQ-031 BURST_MAX=4, ports 1 and 2 always requesting -> four words from port 1, then four from port 2, then port 1, no idle cycles.
REQ-032 BURST_MAX=4, port 0 drops REQ after 2 transfers while port 3 requests -> one cycle with no transfer, then port 3 granted, Pointer=1 afterwards.
REQ-033 OutputREQ high, OutputACK held low 5 cycles with port 0 requesting -> InputACK all 0, OutputData unchanged, Count unchanged; OutputACK high -> transfers resume.
REQ-034 Assert sync_rst mid-burst (LOCKED, Count=2, OutputREQ=1) -> next cycle OutputREQ=0, IDLE, Pointer=0; with TAG_EN, OutputTag=0.

Source files
------------

// File: rtl/handshake_fifo_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared FIFO write port.
// OutputTag is present only when HANDSHAKE_FIFO_ARBITER_TAG_EN is defined.
interface handshake_fifo_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int PORTS = 4
);
    logic [PORTS-1:0]       InputREQ;
    logic [PORTS-1:0]       InputACK;
    logic [PORTS*WIDTH-1:0] InputData;
    logic                   OutputREQ;
    logic                   OutputACK;
    logic [WIDTH-1:0]       OutputData;

`ifdef HANDSHAKE_FIFO_ARBITER_TAG_EN
    logic [$clog2(PORTS)-1:0] OutputTag;

    // master is the arbiter; slave is the requesters plus the FIFO write port
    modport master (
        input  InputREQ, InputData, OutputACK,
        output InputACK, OutputREQ, OutputData, OutputTag
    );
    modport slave (
        output InputREQ, InputData, OutputACK,
        input  InputACK, OutputREQ, OutputData, OutputTag
    );
`else
    // master is the arbiter; slave is the requesters plus the FIFO write port
    modport master (
        input  InputREQ, InputData, OutputACK,
        output InputACK, OutputREQ, OutputData
    );
    modport slave (
        output InputREQ, InputData, OutputACK,
        input  InputACK, OutputREQ, OutputData
    );
`endif
endinterface

// File: rtl/handshake_fifo_arbiter.sv
// Round-robin burst arbiter merging PORTS valid/ack requesters into one registered FIFO write port.
// Define HANDSHAKE_FIFO_ARBITER_TAG_EN to add OutputTag (source port index) beside OutputData.
module handshake_fifo_arbiter #(
    parameter int WIDTH     = 32,
    parameter int PORTS     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic clk_en,
    input  logic sync_rst,
    handshake_fifo_arbiter_if.master bus
);
    localparam int                PTR_W     = $clog2(PORTS);
    localparam logic [PTR_W:0]    PORTS_EXT = (PTR_W+1)'(PORTS);
    localparam logic [PTR_W-1:0]  LAST_PORT = PTR_W'(PORTS-1);
    localparam logic [8:0]        BURST_EXT = 9'(BURST_MAX);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, stateNext;
    logic [PTR_W-1:0] Pointer, LockPort;
    logic [7:0]       Count;
    logic [PTR_W-1:0] idleGrant, grant;
    logic             idleFound, grantValid, lockReq, burstDone;
    logic             canLoad, inXfer, outXfer;
    logic [WIDTH-1:0] grantData;
    logic             outReq;
    logic [WIDTH-1:0] outData;

    function automatic logic [PTR_W-1:0] nextPort(input logic [PTR_W-1:0] p);
        return (p == LAST_PORT) ? '0 : p + PTR_W'(1);
    endfunction

    // Cyclic search for the first requester at or above Pointer.
    always_comb begin
        logic [PTR_W:0] idx;
        idleFound = 1'b0;
        idleGrant = '0;
        idx       = '0;
        for (int k = 0; k < PORTS; k++) begin
            // NOTE: blocking assignments in combinational logic; idx is scratch reused each iteration.
            idx = {1'b0, Pointer} + (PTR_W+1)'(k);
            if (idx >= PORTS_EXT) idx = idx - PORTS_EXT;
            if (!idleFound && bus.InputREQ[idx[PTR_W-1:0]]) begin
                idleFound = 1'b1;
                idleGrant = idx[PTR_W-1:0];
            end
        end
    end

    assign lockReq   = bus.InputREQ[LockPort];
    assign burstDone = ({1'b0, Count} + 9'd1) == BURST_EXT;
    assign canLoad   = ~outReq | bus.OutputACK;
    assign inXfer    = |bus.InputACK;
    assign outXfer   = clk_en & outReq & bus.OutputACK;

    // NOTE: sync_rst is tested ahead of clk_en so reset lands even while the clock is gated.
    always_ff @(posedge clk) begin
        if (sync_rst)    state <= IDLE;
        else if (clk_en) state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (inXfer && BURST_MAX != 1) stateNext = LOCKED;
            LOCKED:  if (!lockReq || (inXfer && burstDone)) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        grant        = idleGrant;
        grantValid   = idleFound;
        bus.InputACK = '0;
        if (state == LOCKED) begin
            grant      = LockPort;
            grantValid = lockReq;
        end
        if (clk_en && !sync_rst && canLoad && grantValid) bus.InputACK[grant] = 1'b1;
    end

    always_comb begin
        grantData = '0;
        for (int i = 0; i < PORTS; i++)
            if (grant == PTR_W'(i)) grantData = bus.InputData[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            Pointer  <= '0;
            LockPort <= '0;
            Count    <= '0;
        end else if (clk_en) begin
            if (state == IDLE) begin
                if (inXfer) begin
                    if (BURST_MAX == 1) begin
                        Pointer <= nextPort(grant);
                    end else begin
                        LockPort <= grant;
                        Count    <= 8'd1;
                    end
                end
            end else begin
                if (inXfer) Count <= Count + 8'd1;
                // Released either by the requester dropping out or by reaching the burst limit.
                if (!lockReq || (inXfer && burstDone)) Pointer <= nextPort(LockPort);
            end
        end
    end

    // A new word overrides a simultaneous drain so the stage can stream one word per cycle.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            outReq  <= 1'b0;
            outData <= '0;
        end else if (inXfer) begin
            outReq  <= 1'b1;
            outData <= grantData;
        end else if (outXfer) begin
            outReq  <= 1'b0;
        end
    end

    assign bus.OutputREQ  = outReq;
    assign bus.OutputData = outData;

`ifdef HANDSHAKE_FIFO_ARBITER_TAG_EN
    logic [PTR_W-1:0] outTag;

    always_ff @(posedge clk) begin
        if (sync_rst)    outTag <= '0;
        else if (inXfer) outTag <= grant;
    end

    assign bus.OutputTag = outTag;
`endif
endmodule

// File: tb/tb_handshake_fifo_arbiter.sv
// Directed bench: dut1 runs BURST_MAX=1 (round robin), dut4 runs BURST_MAX=4 (bursts, release, stall, reset).
`timescale 1ns/1ps
module tb_handshake_fifo_arbiter;
    localparam int WIDTH = 32;
    localparam int PORTS = 4;

    logic clk = 1'b0;
    logic ce1, rst1, ce4, rst4;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    handshake_fifo_arbiter_if #(.WIDTH(WIDTH), .PORTS(PORTS)) bus1 ();
    handshake_fifo_arbiter_if #(.WIDTH(WIDTH), .PORTS(PORTS)) bus4 ();

    handshake_fifo_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS), .BURST_MAX(1)) dut1 (
        .clk(clk), .clk_en(ce1), .sync_rst(rst1), .bus(bus1)
    );
    handshake_fifo_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS), .BURST_MAX(4)) dut4 (
        .clk(clk), .clk_en(ce4), .sync_rst(rst4), .bus(bus4)
    );

    // Word from port p tagged with sequence s, so both source and timing are visible.
    function automatic logic [WIDTH-1:0] word(input int p, input int s);
        return 32'hA000_0000 | (32'(p) << 20) | 32'(s);
    endfunction

    function automatic logic [PORTS*WIDTH-1:0] allData(input int s);
        logic [PORTS*WIDTH-1:0] v;
        for (int i = 0; i < PORTS; i++) v[i*WIDTH +: WIDTH] = word(i, s);
        return v;
    endfunction

    task automatic test_reset;
        bus1.InputREQ = 4'b1111; bus1.OutputACK = 1'b1; bus1.InputData = allData(0);
        bus4.InputREQ = 4'b1111; bus4.OutputACK = 1'b1; bus4.InputData = allData(0);
        @(negedge clk); #1;
        vectors++;
        if (bus1.InputACK !== 4'b0000) begin miscompares++; $display("FAIL rst_ack1: got %b expected 0000", bus1.InputACK); end
        vectors++;
        if (bus4.InputACK !== 4'b0000) begin miscompares++; $display("FAIL rst_ack4: got %b expected 0000", bus4.InputACK); end
        vectors++;
        if (bus4.OutputREQ !== 1'b0) begin miscompares++; $display("FAIL rst_oreq: got %b expected 0", bus4.OutputREQ); end
        vectors++;
        if (bus4.OutputData !== 32'h0) begin miscompares++; $display("FAIL rst_odata: got %h expected 0", bus4.OutputData); end
        vectors++;
        if (dut4.state !== 1'b0 || dut4.Pointer !== 2'd0 || dut4.Count !== 8'd0 || dut4.LockPort !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_regs: got state=%b ptr=%0d cnt=%0d lock=%0d expected all 0", dut4.state, dut4.Pointer, dut4.Count, dut4.LockPort);
        end
`ifdef HANDSHAKE_FIFO_ARBITER_TAG_EN
        vectors++;
        if (bus4.OutputTag !== 2'd0) begin miscompares++; $display("FAIL rst_tag: got %0d expected 0", bus4.OutputTag); end
`endif
    endtask

    task automatic test_round_robin;
        int expPort [6] = '{0, 1, 2, 3, 0, 1};
        @(negedge clk); rst1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++;
            if (bus1.InputACK !== (4'b0001 << expPort[k])) begin
                miscompares++; $display("FAIL rr_ack k=%0d: got %b expected port %0d", k, bus1.InputACK, expPort[k]);
            end
            vectors++;
            if (bus1.OutputREQ !== (k != 0)) begin
                miscompares++; $display("FAIL rr_oreq k=%0d: got %b expected %b", k, bus1.OutputREQ, k != 0);
            end
            if (k != 0) begin
                vectors++;
                if (bus1.OutputData !== word(expPort[k-1], 0)) begin
                    miscompares++; $display("FAIL rr_data k=%0d: got %h expected %h", k, bus1.OutputData, word(expPort[k-1], 0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clk_en;
        rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
        #1;
        vectors++;
        if (bus1.InputACK !== 4'b0001) begin miscompares++; $display("FAIL ce_first: got %b expected 0001", bus1.InputACK); end
        @(negedge clk); ce1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (bus1.InputACK !== 4'b0000) begin miscompares++; $display("FAIL ce_ack k=%0d: got %b expected 0000", k, bus1.InputACK); end
            vectors++;
            if (bus1.OutputREQ !== 1'b1 || bus1.OutputData !== word(0, 0) || dut1.Pointer !== 2'd1) begin
                miscompares++;
                $display("FAIL ce_hold k=%0d: got oreq=%b data=%h ptr=%0d expected 1 %h 1", k, bus1.OutputREQ, bus1.OutputData, dut1.Pointer, word(0, 0));
            end
            @(negedge clk);
        end
        ce1 = 1'b1; #1;
        vectors++;
        if (bus1.InputACK !== 4'b0010) begin miscompares++; $display("FAIL ce_resume: got %b expected 0010", bus1.InputACK); end
        @(negedge clk); ce1 = 1'b0; rst1 = 1'b1; #1;
        vectors++;
        if (bus1.OutputData !== word(1, 0)) begin miscompares++; $display("FAIL ce_resume_data: got %h expected %h", bus1.OutputData, word(1, 0)); end
        @(negedge clk); #1;
        vectors++;
        if (bus1.OutputREQ !== 1'b0 || bus1.OutputData !== 32'h0 || dut1.Pointer !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_over_ce: got oreq=%b data=%h ptr=%0d expected 0 0 0", bus1.OutputREQ, bus1.OutputData, dut1.Pointer);
        end
        ce1 = 1'b1;
    endtask

    task automatic test_burst;
        int expPort [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        bus4.InputREQ = 4'b0110; bus4.OutputACK = 1'b1;
        rst4 = 1'b1; @(negedge clk); rst4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus4.InputData = allData(k);
            #1;
            if (k < 9) begin
                vectors++;
                if (bus4.InputACK !== (4'b0001 << expPort[k])) begin
                    miscompares++; $display("FAIL burst_ack k=%0d: got %b expected port %0d", k, bus4.InputACK, expPort[k]);
                end
            end
            if (k != 0) begin
                vectors++;
                if (bus4.OutputREQ !== 1'b1 || bus4.OutputData !== word(expPort[k-1], k-1)) begin
                    miscompares++;
                    $display("FAIL burst_out k=%0d: got oreq=%b data=%h expected 1 %h", k, bus4.OutputREQ, bus4.OutputData, word(expPort[k-1], k-1));
                end
`ifdef HANDSHAKE_FIFO_ARBITER_TAG_EN
                vectors++;
                if (bus4.OutputTag !== 2'(expPort[k-1])) begin
                    miscompares++; $display("FAIL burst_tag k=%0d: got %0d expected %0d", k, bus4.OutputTag, expPort[k-1]);
                end
`endif
            end
            @(negedge clk);
        end
    endtask

    task automatic test_release;
        bus4.InputREQ = 4'b1001; bus4.OutputACK = 1'b1; bus4.InputData = allData(0);
        rst4 = 1'b1; @(negedge clk); rst4 = 1'b0;
        #1;
        vectors++;
        if (bus4.InputACK !== 4'b0001) begin miscompares++; $display("FAIL rel_ack0: got %b expected 0001", bus4.InputACK); end
        @(negedge clk); #1;
        vectors++;
        if (bus4.InputACK !== 4'b0001 || dut4.state !== 1'b1 || dut4.Count !== 8'd1) begin
            miscompares++; $display("FAIL rel_ack1: got ack=%b state=%b cnt=%0d expected 0001 1 1", bus4.InputACK, dut4.state, dut4.Count);
        end
        @(negedge clk); bus4.InputREQ = 4'b1000; #1;
        vectors++;
        if (bus4.InputACK !== 4'b0000) begin miscompares++; $display("FAIL rel_gap: got %b expected 0000", bus4.InputACK); end
        @(negedge clk); #1;
        vectors++;
        if (bus4.InputACK !== 4'b1000) begin miscompares++; $display("FAIL rel_next: got %b expected 1000", bus4.InputACK); end
        vectors++;
        if (dut4.Pointer !== 2'd1 || dut4.state !== 1'b0 || bus4.OutputREQ !== 1'b0) begin
            miscompares++; $display("FAIL rel_idle: got ptr=%0d state=%b oreq=%b expected 1 0 0", dut4.Pointer, dut4.state, bus4.OutputREQ);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus4.OutputData !== word(3, 0) || dut4.Pointer !== 2'd1 || dut4.LockPort !== 2'd3) begin
            miscompares++;
            $display("FAIL rel_p3: got data=%h ptr=%0d lock=%0d expected %h 1 3", bus4.OutputData, dut4.Pointer, dut4.LockPort, word(3, 0));
        end
    endtask

    task automatic test_backpressure;
        bus4.InputREQ = 4'b0001; bus4.OutputACK = 1'b0; bus4.InputData = allData(0);
        rst4 = 1'b1; @(negedge clk); rst4 = 1'b0;
        #1;
        vectors++;
        if (bus4.InputACK !== 4'b0001) begin miscompares++; $display("FAIL bp_first: got %b expected 0001", bus4.InputACK); end
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk); bus4.InputData = allData(s); #1;
            vectors++;
            if (bus4.InputACK !== 4'b0000) begin miscompares++; $display("FAIL bp_ack s=%0d: got %b expected 0000", s, bus4.InputACK); end
            vectors++;
            if (bus4.OutputREQ !== 1'b1 || bus4.OutputData !== word(0, 0) || dut4.Count !== 8'd1 || dut4.state !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold s=%0d: got oreq=%b data=%h cnt=%0d state=%b expected 1 %h 1 1", s, bus4.OutputREQ, bus4.OutputData, dut4.Count, dut4.state, word(0, 0));
            end
        end
        @(negedge clk); bus4.OutputACK = 1'b1; bus4.InputData = allData(6); #1;
        vectors++;
        if (bus4.InputACK !== 4'b0001) begin miscompares++; $display("FAIL bp_resume: got %b expected 0001", bus4.InputACK); end
        @(negedge clk); #1;
        vectors++;
        if (bus4.OutputData !== word(0, 6) || bus4.OutputREQ !== 1'b1 || dut4.Count !== 8'd2) begin
            miscompares++;
            $display("FAIL bp_after: got data=%h oreq=%b cnt=%0d expected %h 1 2", bus4.OutputData, bus4.OutputREQ, dut4.Count, word(0, 6));
        end
    endtask

    // Continues from test_backpressure: dut4 is LOCKED on port 0 with Count=2 and a word held.
    task automatic test_reset_mid_burst;
        rst4 = 1'b1; #1;
        vectors++;
        if (bus4.InputACK !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_ack: got %b expected 0000", bus4.InputACK); end
        @(negedge clk); #1;
        vectors++;
        if (bus4.OutputREQ !== 1'b0 || dut4.state !== 1'b0 || dut4.Pointer !== 2'd0 || dut4.Count !== 8'd0 || bus4.OutputData !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_rst: got oreq=%b state=%b ptr=%0d cnt=%0d data=%h expected all 0", bus4.OutputREQ, dut4.state, dut4.Pointer, dut4.Count, bus4.OutputData);
        end
`ifdef HANDSHAKE_FIFO_ARBITER_TAG_EN
        vectors++;
        if (bus4.OutputTag !== 2'd0) begin miscompares++; $display("FAIL mid_rst_tag: got %0d expected 0", bus4.OutputTag); end
`endif
        rst4 = 1'b0;
    endtask

    initial begin
        ce1 = 1'b1; ce4 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
        bus1.InputREQ = '0; bus1.OutputACK = 1'b0; bus1.InputData = '0;
        bus4.InputREQ = '0; bus4.OutputACK = 1'b0; bus4.InputData = '0;
        test_reset;
        test_round_robin;
        test_clk_en;
        test_burst;
        test_release;
        test_backpressure;
        test_reset_mid_burst;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
